// File: rtl/extreme_tracker_pkg.sv
// Shared types and constants for the running min/max tracker.
package extreme_tracker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIRST = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

endpackage

// File: rtl/extreme_tracker_if.sv
// Sample stream in, frame result out, for the extreme tracker.
interface extreme_tracker_if #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CNT_W = 4
) ();

  logic             in_start;
  logic             in_select;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_extreme;
  logic [CNT_W-1:0] out_updates;
  logic             out_busy;

  modport master (
    output in_start, in_select, in_valid, in_data,
    input  in_ready, out_valid, out_extreme, out_updates, out_busy
  );

  modport slave (
    input  in_start, in_select, in_valid, in_data,
    output in_ready, out_valid, out_extreme, out_updates, out_busy
  );

endinterface

// File: rtl/cmp_lt_gt.sv
// Combinational unsigned compare of candidate a against stored b.
module cmp_lt_gt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             gt
);

  assign lt = (a < b);
  assign gt = (a > b);

endmodule

// File: rtl/extreme_tracker.sv
// Tracks the min or max of a COUNT_N-sample frame and counts how often the extreme was replaced.
module extreme_tracker
  import extreme_tracker_pkg::*;
#(
  parameter int unsigned WIDTH   = 2,
  parameter int unsigned COUNT_N = 8,
  parameter int unsigned CNT_W   = 4
) (
  input logic              clk,
  input logic              reset,
  extreme_tracker_if.slave bus
);

  state_e           state_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] extreme_q;
  logic [CNT_W-1:0] updates_q;
  logic             ready_q;
  logic             valid_q;
  logic             busy_q;

  logic lt, gt, better, accept;

  cmp_lt_gt #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a  (bus.in_data),
    .b  (extreme_q),
    .lt (lt),
    .gt (gt)
  );

  assign better = (mode_q == MODE_MAX) ? gt : lt;
  assign accept = bus.in_valid && ready_q;

  assign bus.in_ready    = ready_q;
  assign bus.out_valid   = valid_q;
  assign bus.out_extreme = extreme_q;
  assign bus.out_updates = updates_q;
  assign bus.out_busy    = busy_q;

  // All outputs are registered; ready/valid/busy are set on the transition into each state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_MIN;
      cnt_q     <= '0;
      extreme_q <= '0;
      updates_q <= '0;
      ready_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_start) begin
            mode_q    <= bus.in_select;
            cnt_q     <= '0;
            updates_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= ST_FIRST;
          end
        end
        ST_FIRST: begin
          if (accept) begin
            extreme_q <= bus.in_data;
            cnt_q     <= CNT_W'(1);
            if (COUNT_N == 1) begin
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (better) begin
              extreme_q <= bus.in_data;
              updates_q <= updates_q + CNT_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(1);
            // cnt_q still holds the count before this sample
            if (cnt_q == CNT_W'(COUNT_N - 1)) begin
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_extreme_tracker.sv
// Scoreboard bench: driver pushes model results, monitor checks each out_valid pulse.
module tb_extreme_tracker;

  localparam int unsigned WIDTH   = 2;
  localparam int unsigned COUNT_N = 8;
  localparam int unsigned CNT_W   = 4;

  typedef logic [WIDTH-1:0] frame_t [COUNT_N];
  typedef struct {
    int ext;
    int upd;
  } result_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  result_t exp_q[$];

  extreme_tracker_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  extreme_tracker #(
    .WIDTH   (WIDTH),
    .COUNT_N (COUNT_N),
    .CNT_W   (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain running min/max over the frame, counting strict improvements.
  function automatic result_t model(input frame_t s, input bit sel);
    result_t r;
    r.ext = int'(s[0]);
    r.upd = 0;
    for (int i = 1; i < int'(COUNT_N); i++) begin
      if ((sel && int'(s[i]) > r.ext) || (!sel && int'(s[i]) < r.ext)) begin
        r.ext = int'(s[i]);
        r.upd++;
      end
    end
    return r;
  endfunction

  // gap: 0 = valid every cycle, 1 = every other cycle, 2 = random.
  // restart: re-pulse start with flipped select mid-frame. abort: reset after 4 accepts.
  task automatic run_frame(input frame_t s, input bit sel, input int gap,
                           input bit restart, input bit abort);
    int  k = 0;
    int  cyc = 0;
    bit  acc;
    @(negedge clk);
    bus.in_start  = 1'b1;
    bus.in_select = sel;
    @(negedge clk);
    bus.in_start  = 1'b0;
    while (k < int'(COUNT_N) && cyc < 64) begin
      check("in_ready_in_frame", int'(bus.in_ready), 1);
      check("out_busy_in_frame", int'(bus.out_busy), 1);
      bus.in_valid = (gap == 0) || (gap == 1 && cyc % 2 == 0) ||
                     (gap == 2 && $urandom_range(0, 2) != 0);
      bus.in_data  = s[k];
      if (restart && k == 3) begin
        bus.in_start  = 1'b1;
        bus.in_select = ~sel;
      end
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      if (acc) k++;
      if (acc && k == int'(COUNT_N)) exp_q.push_back(model(s, sel));
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_start = 1'b0;
      cyc++;
      if (abort && k == 4) break;
    end
    if (abort) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_out_valid", int'(bus.out_valid), 0);
      check("abort_in_ready", int'(bus.in_ready), 0);
      check("abort_out_busy", int'(bus.out_busy), 0);
      check("abort_out_extreme", int'(bus.out_extreme), 0);
      check("abort_out_updates", int'(bus.out_updates), 0);
    end else if (k < int'(COUNT_N)) begin
      check("frame_timeout", k, int'(COUNT_N));
    end else begin
      check("done_in_ready", int'(bus.in_ready), 0);
      check("done_out_busy", int'(bus.out_busy), 1);
    end
  endtask

  // Monitor: compare every out_valid pulse with the oldest expected result.
  initial begin
    bit prev_valid = 1'b0;
    result_t r;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        check("out_valid_single_cycle", int'(prev_valid), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 1, 0);
        end else begin
          r = exp_q.pop_front();
          check("out_extreme", int'(bus.out_extreme), r.ext);
          check("out_updates", int'(bus.out_updates), r.upd);
        end
      end else if (exp_q.size() != 0) begin
        check("out_valid_latency", 0, 1);
        void'(exp_q.pop_front());
      end
      prev_valid = bus.out_valid;
    end
  end

  initial begin
    frame_t f;
    bit     sel;
    bus.in_start  = 1'b0;
    bus.in_select = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    reset         = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_out_extreme", int'(bus.out_extreme), 0);
    check("reset_out_updates", int'(bus.out_updates), 0);
    check("reset_out_busy", int'(bus.out_busy), 0);

    // Idle: valid without a start is not accepted.
    bus.in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_in_ready", int'(bus.in_ready), 0);
    check("idle_out_busy", int'(bus.out_busy), 0);
    bus.in_valid = 1'b0;

    f = '{2'd2, 2'd3, 2'd1, 2'd1, 2'd0, 2'd2, 2'd3, 2'd0};
    run_frame(f, 1'b0, 0, 1'b0, 1'b0);
    f = '{2'd1, 2'd0, 2'd2, 2'd2, 2'd3, 2'd0, 2'd3, 2'd1};
    run_frame(f, 1'b1, 1, 1'b0, 1'b0);
    f = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
    run_frame(f, 1'b1, 0, 1'b1, 1'b0);
    f = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd1, 2'd1, 2'd1, 2'd1};
    run_frame(f, 1'b0, 0, 1'b0, 1'b1);
    f = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    run_frame(f, 1'b0, 0, 1'b0, 1'b0);

    // Every (extreme, sample) pair in both modes; tail holds the result so only the pair decides.
    for (int m = 0; m < 2; m++) begin
      for (int e = 0; e < 4; e++) begin
        for (int s = 0; s < 4; s++) begin
          f[0] = 2'(e);
          f[1] = 2'(s);
          for (int i = 2; i < int'(COUNT_N); i++)
            f[i] = (m == 1) ? ((s > e) ? 2'(s) : 2'(e)) : ((s < e) ? 2'(s) : 2'(e));
          run_frame(f, m[0], 0, 1'b0, 1'b0);
        end
      end
    end

    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < int'(COUNT_N); i++) f[i] = 2'($urandom_range(0, 3));
      sel = 1'($urandom_range(0, 1));
      run_frame(f, sel, 2, 1'($urandom_range(0, 1)), 1'b0);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
